// File: rtl/relu_frame_arbiter.sv
// -----------------------------------------------------------------------------
// relu_frame_arbiter
//
// Frame-atomic round-robin arbiter that lets SRC_NUM upstream layer engines
// share a single relu activation pipeline. One source is granted for a whole
// frame of FRAME_LEN beats. Its beats are forwarded to the relu with
// fin_start/din_vld framing. A source tag travels alongside the fixed-latency
// activation pipeline, so every result beat comes back labelled with the
// source it came from.
//
// Ports
//   clk          clock
//   reset_n      asynchronous active-low reset
//   src_vld      [SRC_NUM]   beat valid per source
//   src_start    [SRC_NUM]   first beat of a frame (qualified by src_vld)
//   src_data     [SRC_NUM*CH_NUM*DATA_WIDTH] beat payload, source s at
//                slice s*CH_NUM*DATA_WIDTH
//   src_rdy      [SRC_NUM]   beat accepted when src_vld & src_rdy
//   act_start    to relu fin_start
//   act_vld      to relu din_vld
//   act_din      [CH_NUM*DATA_WIDTH] to relu din
//   act_fstart   from relu fout_start
//   act_dvld     from relu dout_vld
//   act_dout     [CH_NUM*DATA_WIDTH] from relu dout
//   res_vld      result beat valid
//   res_start    result first beat of frame
//   res_src      [$clog2(SRC_NUM)] originating source of the result beat
//   res_data     [CH_NUM*DATA_WIDTH] result payload
//   busy         a frame is currently granted
//   proto_err    one-cycle pulse on a framing violation
// -----------------------------------------------------------------------------
module relu_frame_arbiter #(
    parameter int SRC_NUM    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CH_NUM     = 128,
    parameter int FRAME_LEN  = 64,
    parameter int ACT_LAT    = 1,
    localparam int BEAT_W    = CH_NUM * DATA_WIDTH,
    localparam int SRC_W     = $clog2(SRC_NUM),
    localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [SRC_NUM-1:0]         src_vld,
    input  logic [SRC_NUM-1:0]         src_start,
    input  logic [SRC_NUM*BEAT_W-1:0]  src_data,
    output logic [SRC_NUM-1:0]         src_rdy,
    output logic                       act_start,
    output logic                       act_vld,
    output logic [BEAT_W-1:0]          act_din,
    input  logic                       act_fstart,
    input  logic                       act_dvld,
    input  logic [BEAT_W-1:0]          act_dout,
    output logic                       res_vld,
    output logic                       res_start,
    output logic [SRC_W-1:0]           res_src,
    output logic [BEAT_W-1:0]          res_data,
    output logic                       busy,
    output logic                       proto_err
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Control state
    state_t             state_q, state_d;
    logic [SRC_W-1:0]   gnt_q, gnt_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Activation-side registered outputs
    logic               act_vld_q, act_vld_d;
    logic               act_start_q, act_start_d;
    logic [BEAT_W-1:0]  act_din_q, act_din_d;
    logic               perr_q, perr_d;

    // Tag chain: entry 0 is aligned with act_vld, entry ACT_LAT with act_dvld
    logic [SRC_W-1:0]   tag_q [ACT_LAT+1];

    // Result-side registers
    logic               res_vld_q;
    logic               res_start_q;
    logic [SRC_W-1:0]   res_src_q;
    logic [BEAT_W-1:0]  res_data_q;

    // Arbitration helpers
    logic [SRC_NUM-1:0] req;
    logic [SRC_W-1:0]   cand;
    logic [SRC_W-1:0]   win_idx;
    logic               win_found;

    logic [BEAT_W-1:0]  beat_sel;
    logic               accept;
    logic               first_beat;

    assign req        = src_vld & src_start;
    assign beat_sel   = src_data[int'(gnt_q)*BEAT_W +: BEAT_W];
    assign accept     = (state_q == XFER) && src_vld[gnt_q];
    assign first_beat = (cnt_q == '0);

    // Rotating-priority search starting at ptr+1. The loop walks from the
    // lowest priority (ptr+SRC_NUM == ptr) up to the highest (ptr+1). The
    // last hit therefore wins, which avoids any early exit.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = SRC_NUM; k >= 1; k--) begin
            cand = SRC_W'((int'(ptr_q) + k) % SRC_NUM);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Ready is a pure decode of the grant state, so an upstream source sees
    // it without an extra register stage.
    always_comb begin
        src_rdy = '0;
        if (state_q == XFER) begin
            src_rdy[gnt_q] = 1'b1;
        end
    end

    // Next-state and beat handling
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        act_vld_d   = 1'b0;
        act_start_d = 1'b0;
        act_din_d   = act_din_q;
        perr_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d   = win_idx;
                    state_d = XFER;
                end
            end

            XFER: begin
                if (accept) begin
                    act_vld_d   = 1'b1;
                    act_din_d   = beat_sel;
                    // A start flag always opens a frame. A missing start on
                    // the first beat or a stray start later is flagged, but
                    // the beat is never dropped.
                    act_start_d = first_beat || src_start[gnt_q];
                    perr_d      = first_beat ^ src_start[gnt_q];
                    cnt_d       = act_start_d ? CNT_W'(1) : cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(FRAME_LEN)) begin
                        // Frame complete. The grant is released and the
                        // pointer is moved past this source. IDLE costs one
                        // cycle, which gives the gap between frames.
                        cnt_d   = '0;
                        ptr_d   = gnt_q;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            ptr_q       <= SRC_W'(SRC_NUM - 1);
            cnt_q       <= '0;
            act_vld_q   <= 1'b0;
            act_start_q <= 1'b0;
            act_din_q   <= '0;
            perr_q      <= 1'b0;
            for (int i = 0; i <= ACT_LAT; i++) begin
                tag_q[i] <= '0;
            end
            res_vld_q   <= 1'b0;
            res_start_q <= 1'b0;
            res_src_q   <= '0;
            res_data_q  <= '0;
        end else begin
            // Arbitration / framing stage
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            act_vld_q   <= act_vld_d;
            act_start_q <= act_start_d;
            act_din_q   <= act_din_d;
            perr_q      <= perr_d;

            // Tag stage: entry 0 follows the beat on act_*. The rest shift
            // every cycle, matching the relu's fixed latency.
            if (accept) begin
                tag_q[0] <= gnt_q;
            end
            for (int i = 1; i <= ACT_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end

            // Result stage
            res_vld_q   <= act_dvld;
            res_start_q <= act_fstart;
            res_src_q   <= tag_q[ACT_LAT];
            res_data_q  <= act_dout;
        end
    end

    assign busy      = (state_q == XFER);
    assign act_vld   = act_vld_q;
    assign act_start = act_start_q;
    assign act_din   = act_din_q;
    assign proto_err = perr_q;
    assign res_vld   = res_vld_q;
    assign res_start = res_start_q;
    assign res_src   = res_src_q;
    assign res_data  = res_data_q;

endmodule

// File: doc/relu_frame_arbiter.md
Name: relu_frame_arbiter

Overview:
- Frame-atomic round-robin arbiter that lets SRC_NUM upstream layer engines share one relu activation pipeline.
- Grants one source for a whole frame of FRAME_LEN beats and forwards its beats with fin_start/din_vld framing.
- Carries a source tag alongside the fixed-latency activation pipeline so results return labelled with their originating source.
- Sits between the layer outputs and the single relu instance.

Parameters:
- SRC_NUM, 4, number of requesting sources (2..16).
- DATA_WIDTH, 8, bits per channel sample, signed fixed point.
- CH_NUM, 128, channels per beat.
- FRAME_LEN, 64, beats per frame (>=1).
- ACT_LAT, 1, fixed latency of the activation pipeline in cycles (>=1).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- src_vld  in  SRC_NUM  beat valid per source
- src_start  in  SRC_NUM  first beat of a frame, qualified by src_vld
- src_data  in  SRC_NUM x CH_NUM x DATA_WIDTH  beat payload per source
- src_rdy  out  SRC_NUM  beat accepted when src_vld&src_rdy
- act_start  out  1  to relu fin_start
- act_vld  out  1  to relu din_vld
- act_din  out  CH_NUM x DATA_WIDTH  to relu din
- act_fstart  in  1  from relu fout_start
- act_dvld  in  1  from relu dout_vld
- act_dout  in  CH_NUM x DATA_WIDTH  from relu dout
- res_vld  out  1  result beat valid
- res_start  out  1  result first beat of frame
- res_src  out  $clog2(SRC_NUM)  originating source of the result beat
- res_data  out  CH_NUM x DATA_WIDTH  result payload
- busy  out  1  a frame is granted
- proto_err  out  1  one-cycle pulse on a framing violation

Behaviour:
- Async reset: all outputs 0, FSM=IDLE, beat counter 0, tag pipe 0, rr pointer = SRC_NUM-1 so source 0 has first priority. Reset mid-frame abandons the frame; nothing is replayed.
- FSM IDLE:
  - Candidates are sources with src_vld&src_start.
  - Winner is the first candidate searching ptr+1, ptr+2, ... modulo SRC_NUM.
  - Register gnt=winner, go to XFER. src_rdy=0 in IDLE.
- FSM XFER:
  - src_rdy is one-hot at gnt and driven combinationally from state; other sources see rdy=0.
  - The granted source may stall by dropping src_vld; the grant is held indefinitely.
- Accepted beat handling: act_vld=1, act_din=src_data[gnt], and act_start=1 iff beat counter==0, all registered one cycle after acceptance. Otherwise act_vld=0 and act_start=0; act_din holds its last value.
- Beat counter increments per accepted beat.
- Last beat: on acceptance of beat FRAME_LEN-1, set counter=0, ptr=gnt, go to IDLE. This gives a mandatory one-cycle gap between frames.
- Violation, first beat of a frame without src_start:
  - Beat is still accepted and forwarded with act_start=1.
  - proto_err pulses.
- Violation, src_start on a non-first beat:
  - proto_err pulses, counter restarts at 1.
  - Beat forwarded with act_start=1; frame length restarts from that beat.
- busy=1 in XFER.
- Tag pipe: the gnt index is shifted into an ACT_LAT-deep register chain aligned with act_vld.
- Result path, registered one cycle after the act_* inputs:
  - res_vld=act_dvld, res_start=act_fstart, res_data=act_dout, res_src=tag aligned to act_dvld.
  - Total latency from acceptance to res_vld is ACT_LAT+2 cycles.
- No backpressure on the result side; the consumer must always accept.
- Simultaneous requests with the same ptr are resolved purely by the rotating priority. A source requesting continuously waits at most SRC_NUM-1 frames.
- Width rules: no arithmetic on payload; data passes bit-exact. The counter is $clog2(FRAME_LEN+1) bits.

Test Plan:
- Reset, then src 0 sends one frame of FRAME_LEN=4 with data 8'h05, 8'h85, 8'h7F, 8'h80 in all channels -> act_start on first beat only; res_src=0 and res_data 05,00,7F,00 at ACT_LAT+2 cycles per beat; busy drops after beat 4.
- Sources 0, 1 and 3 request simultaneously and continuously -> grant order 0,1,3,0,1,3, with a one-cycle IDLE gap between frames.
- Granted src 2 drops src_vld for 5 cycles mid-frame -> no act_vld during the stall, grant not lost, and src 1 requesting meanwhile is not served until src 2's frame ends.
- src_start asserted on beat 2 of a 4-beat frame -> proto_err pulses once, act_start=1 on that beat, frame ends 4 beats later.
- reset_n asserted on beat 2 of a frame -> all outputs 0 immediately; after release, src 0 wins despite an earlier grant to src 3.
